// File: rtl/systolic_ctrl.sv
// systolic_ctrl -- sequencer for an N x N weight-stationary systolic array.
//
// Takes one job command at a time, optionally streams N weight rows into the
// array (LOAD), then streams M input vectors through it (COMPUTE) and emits
// per-row input skew enables and per-column bottom-psum valid strobes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/ready          job handshake (ready only in IDLE)
//   cmd_rows, cmd_reload     input vector count M, reload-weights request
//   stall                    backpressure, honoured in COMPUTE only
//   wt_rd_en, wt_rd_addr     weight buffer read (1-cycle latency)
//   load_weight, load_row    array weight write control
//   in_rd_en, in_rd_addr     input buffer read (1-cycle latency)
//   in_lane_en[N]            per-row skew register enable
//   start                    array compute enable
//   out_valid[N]             column c bottom psum valid
//   busy, done               state != IDLE, one-cycle completion pulse
//
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds perf_busy_cyc and
// perf_stall_cyc saturating 32-bit event counters.

// Per-lane window decode: lane r is enabled for LO_IN <= k < LO_IN+M and its
// column output is valid for LO_OUT <= k < LO_OUT+M. Subtract-then-compare
// avoids any overflow on LO+M.
module systolic_ctrl_lane #(
   parameter int KW     = 9,
   parameter int LO_IN  = 1,
   parameter int LO_OUT = 5
) (
   input  logic [KW-1:0] k,
   input  logic [KW-1:0] m,
   input  logic          en,
   output logic          lane_en,
   output logic          col_vld
);
   assign lane_en = en && (k >= KW'(LO_IN))  && ((k - KW'(LO_IN))  < m);
   assign col_vld = en && (k >= KW'(LO_OUT)) && ((k - KW'(LO_OUT)) < m);
endmodule

module systolic_ctrl #(
   parameter int N        = 4,
   parameter int MAX_ROWS = 256,
   parameter int CNT_W    = $clog2(MAX_ROWS+1),
   localparam int AW      = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_rows,
   input  logic             cmd_reload,
   input  logic             stall,
   output logic             wt_rd_en,
   output logic [AW-1:0]    wt_rd_addr,
   output logic             load_weight,
   output logic [AW-1:0]    load_row,
   output logic             in_rd_en,
   output logic [CNT_W-1:0] in_rd_addr,
   output logic [N-1:0]     in_lane_en,
   output logic             start,
   output logic [N-1:0]     out_valid,
   output logic             busy,
   output logic             done
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [31:0]      perf_busy_cyc,
   output logic [31:0]      perf_stall_cyc
`endif
);
   // counter must reach M+2N-1 in COMPUTE and N in LOAD
   localparam int KW = $clog2(MAX_ROWS + 2*N + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

   state_t           state, state_nx;
   logic [KW-1:0]    cnt, cnt_nx;
   logic [CNT_W-1:0] m_q, m_nx, m_clamp;
   logic             wts_loaded, wts_nx;
   logic [KW-1:0]    m_k;
   logic             lane_gate;

   assign m_clamp   = (cmd_rows > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : cmd_rows;
   assign m_k       = KW'(m_q);
   assign lane_gate = (state == COMPUTE) && !stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         m_q        <= '0;
         wts_loaded <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         m_q        <= m_nx;
         wts_loaded <= wts_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      m_nx        = m_q;
      wts_nx      = wts_loaded;
      cmd_ready   = 1'b0;
      wt_rd_en    = 1'b0;
      wt_rd_addr  = '0;
      load_weight = 1'b0;
      load_row    = '0;
      in_rd_en    = 1'b0;
      in_rd_addr  = '0;
      start       = 1'b0;
      done        = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               m_nx   = m_clamp;
               cnt_nx = '0;
               // weights must exist before any compute, so reload is forced
               if (cmd_reload || !wts_loaded) state_nx = LOAD;
               else if (m_clamp != '0)        state_nx = COMPUTE;
               else                           state_nx = DONE;
            end
         end
         LOAD: begin
            // read issued at j lands in the array at j+1 (buffer latency)
            if (cnt < KW'(N)) begin
               wt_rd_en   = 1'b1;
               wt_rd_addr = cnt[AW-1:0];
            end
            if (cnt != '0) begin
               load_weight = 1'b1;
               load_row    = cnt[AW-1:0] - AW'(1);
            end
            if (cnt == KW'(N)) begin
               wts_nx   = 1'b1;
               cnt_nx   = '0;
               state_nx = (m_q != '0) ? COMPUTE : DONE;
            end else begin
               cnt_nx = cnt + KW'(1);
            end
         end
         COMPUTE: begin
            if (!stall) begin
               start = 1'b1;
               if (cnt < m_k) begin
                  in_rd_en   = 1'b1;
                  in_rd_addr = cnt[CNT_W-1:0];
               end
               if (cnt == m_k + KW'(2*N-1)) begin
                  cnt_nx   = '0;
                  state_nx = DONE;
               end else begin
                  cnt_nx = cnt + KW'(1);
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // row r sees its first input at k=r+1 (skew); column c's bottom psum
   // emerges N cycles after its first product, i.e. at k=c+N+1
   for (genvar r = 0; r < N; r++) begin : g_lane
      systolic_ctrl_lane #(.KW(KW), .LO_IN(r+1), .LO_OUT(r+N+1)) u_lane (
         .k       (cnt),
         .m       (m_k),
         .en      (lane_gate),
         .lane_en (in_lane_en[r]),
         .col_vld (out_valid[r])
      );
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_busy_cyc  <= '0;
         perf_stall_cyc <= '0;
      end else begin
         if (busy && (perf_busy_cyc != '1))
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
         if ((state == COMPUTE) && stall && (perf_stall_cyc != '1))
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, MAX_ROWS=256). Each job is traced
// cycle by cycle relative to its accept cycle A (offset i = cycle A+i) and
// then compared against hand-derived values.
module tb_systolic_ctrl;
   localparam int N = 4;
   localparam int MAX_ROWS = 256;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_rows = '0;
   logic             cmd_reload = 1'b0;
   logic             stall = 1'b0;
   logic             wt_rd_en;
   logic [1:0]       wt_rd_addr;
   logic             load_weight;
   logic [1:0]       load_row;
   logic             in_rd_en;
   logic [CNT_W-1:0] in_rd_addr;
   logic [N-1:0]     in_lane_en;
   logic             start;
   logic [N-1:0]     out_valid;
   logic             busy;
   logic             done;

   systolic_ctrl #(.N(N), .MAX_ROWS(MAX_ROWS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rows(cmd_rows), .cmd_reload(cmd_reload), .stall(stall),
      .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .load_weight(load_weight),
      .load_row(load_row), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
      .in_lane_en(in_lane_en), .start(start), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic             tr_wen [0:299];
   logic [1:0]       tr_waddr [0:299];
   logic             tr_lw [0:299];
   logic [1:0]       tr_lrow [0:299];
   logic             tr_ien [0:299];
   logic [CNT_W-1:0] tr_iaddr [0:299];
   logic [3:0]       tr_lane [0:299];
   logic [3:0]       tr_ov [0:299];
   logic             tr_start [0:299];
   logic             tr_done [0:299];
   logic             tr_busy [0:299];
   logic             stall_sched [0:299];

   // expected tables for M=3, indexed by k = 0..10
   logic [3:0] ov_m3   [0:10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
   logic [3:0] lane_m3 [0:10] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // call at posedge+1 in IDLE; returns at posedge+1 of cycle A+1
   task automatic issue(input int rows, input logic reload);
      cmd_valid  = 1'b1;
      cmd_rows   = CNT_W'(rows);
      cmd_reload = reload;
      @(negedge clk);
      chk("cmd_ready at accept", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      cmd_reload = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 1; i <= n; i++) begin
         stall = stall_sched[i];
         @(negedge clk);
         tr_wen[i]   = wt_rd_en;    tr_waddr[i] = wt_rd_addr;
         tr_lw[i]    = load_weight; tr_lrow[i]  = load_row;
         tr_ien[i]   = in_rd_en;    tr_iaddr[i] = in_rd_addr;
         tr_lane[i]  = in_lane_en;  tr_ov[i]    = out_valid;
         tr_start[i] = start;       tr_done[i]  = done;
         tr_busy[i]  = busy;
         if (load_weight && start) chk("lw and start together", 1, 0);
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " cmd_ready"}, 32'(cmd_ready), 1);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " start"}, 32'(start), 0);
      chk({tag, " load_weight"}, 32'(load_weight), 0);
      chk({tag, " wt_rd_en"}, 32'(wt_rd_en), 0);
      chk({tag, " in_rd_en"}, 32'(in_rd_en), 0);
      chk({tag, " in_lane_en"}, 32'(in_lane_en), 0);
      chk({tag, " out_valid"}, 32'(out_valid), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 300; i++) stall_sched[i] = 1'b0;
      #3;
      do_reset();

      // job 1: M=3, reload=1
      issue(3, 1'b1);
      run(17);
      for (int i = 1; i <= 4; i++) begin
         chk("j1 wt_rd_en", 32'(tr_wen[i]), 1);
         chk("j1 wt_rd_addr", 32'(tr_waddr[i]), 32'(i-1));
      end
      chk("j1 wt_rd_en off5", 32'(tr_wen[5]), 0);
      chk("j1 lw off1", 32'(tr_lw[1]), 0);
      for (int i = 2; i <= 5; i++) begin
         chk("j1 load_weight", 32'(tr_lw[i]), 1);
         chk("j1 load_row", 32'(tr_lrow[i]), 32'(i-2));
      end
      chk("j1 lw off6", 32'(tr_lw[6]), 0);
      chk("j1 start off5", 32'(tr_start[5]), 0);
      for (int k = 0; k <= 10; k++) begin
         chk("j1 start", 32'(tr_start[k+6]), 1);
         chk("j1 out_valid", 32'(tr_ov[k+6]), 32'(ov_m3[k]));
         chk("j1 in_lane_en", 32'(tr_lane[k+6]), 32'(lane_m3[k]));
         chk("j1 in_rd_en", 32'(tr_ien[k+6]), (k < 3) ? 1 : 0);
         if (k < 3) chk("j1 in_rd_addr", 32'(tr_iaddr[k+6]), 32'(k));
      end
      chk("j1 done off16", 32'(tr_done[16]), 0);
      chk("j1 start off17", 32'(tr_start[17]), 0);
      chk("j1 done off17", 32'(tr_done[17]), 1);
      chk("j1 busy off17", 32'(tr_busy[17]), 1);

      // job 2: M=1, reload=0 -> straight to COMPUTE, 9 cycles
      issue(1, 1'b0);
      run(10);
      n = 0;
      for (int i = 1; i <= 10; i++) n += 32'(tr_lw[i]);
      chk("j2 load_weight count", n, 0);
      n = 0;
      for (int i = 1; i <= 10; i++) n += 32'(tr_start[i]);
      chk("j2 start count", n, 9);
      chk("j2 in_rd_en k0", 32'(tr_ien[1]), 1);
      chk("j2 in_rd_en k1", 32'(tr_ien[2]), 0);
      chk("j2 out_valid k5", 32'(tr_ov[6]), 32'h1);
      chk("j2 out_valid k6", 32'(tr_ov[7]), 32'h2);
      chk("j2 out_valid k7", 32'(tr_ov[8]), 32'h4);
      chk("j2 out_valid k8", 32'(tr_ov[9]), 32'h8);
      chk("j2 done off9", 32'(tr_done[9]), 0);
      chk("j2 done off10", 32'(tr_done[10]), 1);

      // job 3: fresh reset, reload=0 still forces LOAD
      do_reset();
      issue(2, 1'b0);
      run(16);
      n = 0;
      for (int i = 1; i <= 16; i++) n += 32'(tr_lw[i]);
      chk("j3 forced load count", n, 4);
      chk("j3 lw off2", 32'(tr_lw[2]), 1);
      n = 0;
      for (int i = 1; i <= 16; i++) n += 32'(tr_start[i]);
      chk("j3 start count", n, 10);
      chk("j3 start off6", 32'(tr_start[6]), 1);
      chk("j3 done off16", 32'(tr_done[16]), 1);

      // job 4: M=3, stall during k=2 for two cycles (offsets 3,4)
      stall_sched[3] = 1'b1;
      stall_sched[4] = 1'b1;
      issue(3, 1'b0);
      run(14);
      stall_sched[3] = 1'b0;
      stall_sched[4] = 1'b0;
      for (int i = 3; i <= 4; i++) begin
         chk("j4 stall start", 32'(tr_start[i]), 0);
         chk("j4 stall in_rd_en", 32'(tr_ien[i]), 0);
         chk("j4 stall lane", 32'(tr_lane[i]), 0);
         chk("j4 stall ov", 32'(tr_ov[i]), 0);
      end
      chk("j4 in_rd_en resume", 32'(tr_ien[5]), 1);
      chk("j4 in_rd_addr resume", 32'(tr_iaddr[5]), 2);
      chk("j4 lane resume k2", 32'(tr_lane[5]), 32'h3);
      chk("j4 ov k4", 32'(tr_ov[7]), 0);
      chk("j4 ov k5", 32'(tr_ov[8]), 32'h1);
      chk("j4 ov k10", 32'(tr_ov[13]), 32'h8);
      chk("j4 done off12", 32'(tr_done[12]), 0);
      chk("j4 done off14", 32'(tr_done[14]), 1);

      // job 5: M=0 with weights loaded -> done at A+1
      issue(0, 1'b0);
      run(1);
      chk("j5 done off1", 32'(tr_done[1]), 1);
      chk("j5 start off1", 32'(tr_start[1]), 0);
      chk("j5 lw off1", 32'(tr_lw[1]), 0);

      // job 6: cmd_rows=300 clamps to 256
      issue(300, 1'b0);
      run(265);
      n = 0;
      for (int i = 1; i <= 265; i++) n += 32'(tr_ien[i]);
      chk("j6 input read count", n, 256);
      chk("j6 last in_rd_addr", 32'(tr_iaddr[256]), 255);
      chk("j6 in_rd_en k256", 32'(tr_ien[257]), 0);
      chk("j6 done off264", 32'(tr_done[264]), 0);
      chk("j6 done off265", 32'(tr_done[265]), 1);

      // job 7: reset asserted at k=4 of COMPUTE
      issue(3, 1'b0);
      run(4);
      chk("j7 start at k4", 32'(start), 1);
      rst = 1'b0;
      #1;
      chk_idle_outputs("j7 mid-job reset");
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n += 32'(done);
      end
      chk("j7 no done after abort", n, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      issue(1, 1'b0);
      run(15);
      n = 0;
      for (int i = 1; i <= 15; i++) n += 32'(tr_lw[i]);
      chk("j7 forced load after reset", n, 4);
      chk("j7 done off15", 32'(tr_done[15]), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for an N×N weight-stationary systolic array of `pe` tiles. Accepts a job command and drives the array's `load_weight` and `start` controls, issuing reads to the weight buffer and the input buffer. Generates per-row input skew enables and per-column output-valid strobes so downstream logic can capture each bottom-row psum. Sits between the job/command front end and the array plus its buffers.

## Interface
- `N`, 4, array dimension (rows = columns = N); ≥2
- `MAX_ROWS`, 256, maximum input vectors per job
- `CNT_W`, `$clog2(MAX_ROWS+1)`, row-count width (derived)
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  job request
- `cmd_ready`  out  1  high in IDLE only
- `cmd_rows`  in  CNT_W  input vector count M
- `cmd_reload`  in  1  1 = load new weights before compute
- `stall`  in  1  downstream backpressure, honoured in COMPUTE only
- `wt_rd_en`  out  1  weight buffer read strobe (1-cycle read latency)
- `wt_rd_addr`  out  $clog2(N)  weight row to read
- `load_weight`  out  1  to all PEs
- `load_row`  out  $clog2(N)  array row being written while `load_weight`=1
- `in_rd_en`  out  1  input buffer read strobe (1-cycle latency)
- `in_rd_addr`  out  CNT_W  input vector index
- `in_lane_en`  out  N  per-row skew register enable
- `start`  out  1  to all PEs
- `out_valid`  out  N  column c bottom psum valid this cycle
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- Accept: `cmd_valid & cmd_ready` in IDLE; latch M = min(`cmd_rows`, MAX_ROWS) and reload flag.
- Reload forced to 1 if `wts_loaded` (internal, cleared by reset) is 0. Set at end of LOAD.
- Next state after accept: LOAD if reload; else COMPUTE if M>0; else DONE.
- LOAD, counter j = 0..N: `wt_rd_en`=1, `wt_rd_addr`=j for j<N; `load_weight`=1, `load_row`=j-1 for 1≤j≤N. `start`=0 throughout. Exit to COMPUTE if M>0, else DONE. `stall` ignored.
- COMPUTE, counter k = 0..M+2N-1; `start`=1 while not stalled.
  - `in_rd_en`=1 and `in_rd_addr`=k for k<M.
  - `in_lane_en[r]`=1 for r+1 ≤ k ≤ r+M.
  - `out_valid[c]`=1 for c+N+1 ≤ k ≤ c+N+M.
- COMPUTE stall: when `stall`=1, k holds and `start`, `in_rd_en`, `in_lane_en`, `out_valid` are all 0. Buffers hold read data when not strobed.
- DONE: `done`=1 for one cycle, then IDLE.
- `load_weight` and `start` are never high in the same cycle.
- `cmd_valid` outside IDLE is ignored and not queued.

## Timing
- Reset values: `cmd_ready`=1 (IDLE); every other output 0; counters 0; `wts_loaded`=0.
- Reset assertion mid-job: abort immediately to IDLE; no `done` pulse.
- Accept cycle A → first LOAD cycle A+1.
- LOAD lasts N+1 cycles; COMPUTE lasts M+2N unstalled cycles; DONE lasts 1 cycle.
- Minimum accept-to-accept spacing: one IDLE cycle after DONE.
- Outputs are decoded from registered state and counters only; no combinational path from inputs to outputs except `stall` gating in COMPUTE.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined: adds two outputs, `perf_busy_cyc` [31:0] (cycles with `busy`=1) and `perf_stall_cyc` [31:0] (COMPUTE cycles with `stall`=1).
  - Both reset to 0 on `rst` and saturate at all-ones.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- N=4, after reset: cmd M=3, reload=1 → `wt_rd_en` A+1..A+4 with addr 0..3; `load_weight` A+2..A+5 with row 0..3; COMPUTE A+6..A+16; `out_valid[0]` k=5..7, `out_valid[3]` k=8..10; `done` at A+17.
- Follow-up cmd M=1, reload=0 → no `load_weight`; COMPUTE 9 cycles; `out_valid[2]` only at k=7.
- First cmd after reset with reload=0, M=2 → LOAD still occurs (forced), then 10 COMPUTE cycles.
- M=3, `stall` high at k=2 for 2 cycles → k frozen and strobes 0 during stall; all later `out_valid` windows and `done` shift by 2.
- M=0, reload=0 (weights already loaded) → `done` at A+1. `cmd_rows`=300 with MAX_ROWS=256 → 256 input reads.
- `rst` low at k=4 of COMPUTE → all outputs 0 and `cmd_ready`=1 immediately; no `done`; next job with reload=0 forces LOAD.
